// File: rtl/led_shift_tx.sv
// -----------------------------------------------------------------------------
// led_shift_tx
//
// Frame consumer for the LED shift-register driver chain. A single-cycle
// enable pulse captures a DATA_W-bit frame, which is then clocked out on
// led_sclk/led_sdi (one bit per sclk period, CLK_DIV clk cycles per
// half-period). After the last bit led_le is held high for LE_CYCLES cycles
// to latch the chain, followed by a one-cycle done pulse.
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous reset, active-high
//   enable     in   1       frame request, accepted only while idle
//   data_in    in   DATA_W  frame data, sampled in the accepting cycle
//   led_sclk   out  1       serial shift clock
//   led_sdi    out  1       serial data, stable across a full sclk period
//   led_le     out  1       latch enable
//   busy       out  1       frame in flight (shift + latch phases)
//   done       out  1       one-cycle pulse after led_le falls
//   drop       out  1       one-cycle pulse for an enable seen while busy
//   frame_cnt  out  16      completed frames, wrapping
// -----------------------------------------------------------------------------
module led_shift_tx #(
    parameter int DATA_W    = 128,
    parameter int CLK_DIV   = 2,
    parameter int LE_CYCLES = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic              led_sclk,
    output logic              led_sdi,
    output logic              led_le,
    output logic              busy,
    output logic              done,
    output logic              drop,
    output logic [15:0]       frame_cnt
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int LE_W  = $clog2(LE_CYCLES) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [LE_W-1:0]   le_cnt_q, le_cnt_d;
    logic              led_sclk_q, led_sclk_d;
    logic              led_sdi_q, led_sdi_d;
    logic              led_le_q, led_le_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    // Bit order is fixed at elaboration: the bit on the wire is always the
    // one at the "head" end of the shift register, and advancing moves the
    // next bit into the head position.
    logic [DATA_W-1:0] shift_adv;
    logic              head_bit;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_adv = {shift_q[DATA_W-2:0], 1'b0};
            assign head_bit  = shift_d[DATA_W-1];
        end else begin : g_lsb_first
            assign shift_adv = {1'b0, shift_q[DATA_W-1:1]};
            assign head_bit  = shift_d[0];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        le_cnt_d    = le_cnt_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Any request arriving outside IDLE is refused and reported.
        drop_d = enable && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        le_cnt_d = '0;
                        state_d  = ST_LATCH;
                    end else begin
                        // Data only changes on the falling sclk transition,
                        // so sdi is stable for the whole sclk period.
                        shift_d   = shift_adv;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = ST_SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (le_cnt_q == LE_LAST) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    le_cnt_d = le_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so that the registered
        // pins line up exactly with the state they describe.
        led_sclk_d = (state_d == ST_SHIFT_HI);
        led_le_d   = (state_d == ST_LATCH);
        busy_d     = (state_d != ST_IDLE);
        led_sdi_d  = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? head_bit : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            le_cnt_q    <= '0;
            led_sclk_q  <= 1'b0;
            led_sdi_q   <= 1'b0;
            led_le_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            le_cnt_q    <= le_cnt_d;
            led_sclk_q  <= led_sclk_d;
            led_sdi_q   <= led_sdi_d;
            led_le_q    <= led_le_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign led_sclk  = led_sclk_q;
    assign led_sdi   = led_sdi_q;
    assign led_le    = led_le_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign drop      = drop_q;
    assign frame_cnt = frame_cnt_q;

endmodule
